// File: rtl/flash_rom_loader.sv
// flash_rom_loader: boot sequencer that copies a ROM image from SPI flash into SRAM.
// Optional FLASH_ROM_LOADER_FAST_READ_EN selects FAST READ (0x0B) with one dummy byte.
module flash_rom_loader #(
  parameter logic [23:0] FLASH_BASE = 24'h010000,
  parameter logic [18:0] SRAM_BASE  = 19'h00000,
  parameter int          ROM_BYTES  = 16384,
  parameter int          WE_CYCLES  = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_start,
  output logic        o_busy,
  output logic        o_done,
  output logic        o_spi_cs_n,
  output logic        o_spi_start,
  output logic [7:0]  o_spi_txd,
  input  logic [7:0]  i_spi_rxd,
  input  logic        i_spi_done,
  output logic [18:0] o_sram_addr,
  output logic [7:0]  o_sram_dout,
  output logic        o_sram_we_n
);

  localparam logic [16:0] LAST_BYTE = 17'(ROM_BYTES - 1);
  localparam logic [7:0]  WE_LAST   = 8'(WE_CYCLES - 1);
`ifdef FLASH_ROM_LOADER_FAST_READ_EN
  localparam logic [7:0]  CMD_BYTE  = 8'h0B;
`else
  localparam logic [7:0]  CMD_BYTE  = 8'h03;
`endif

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_CS_SETUP   = 4'd1,
    ST_CMD        = 4'd2,
    ST_ADDR2      = 4'd3,
    ST_ADDR1      = 4'd4,
    ST_ADDR0      = 4'd5,
    ST_RD_REQ     = 4'd6,
    ST_RD_WAIT    = 4'd7,
    ST_WR_SETUP   = 4'd8,
    ST_WR_PULSE   = 4'd9,
    ST_WR_HOLD    = 4'd10,
    ST_CS_RELEASE = 4'd11,
    ST_DONE       = 4'd12
`ifdef FLASH_ROM_LOADER_FAST_READ_EN
    , ST_DUMMY    = 4'd13
`endif
  } state_t;

  state_t      r_state, w_state;
  logic        r_busy, w_busy;
  logic        r_done, w_done;
  logic        r_cs_n, w_cs_n;
  logic        r_spi_start, w_spi_start;
  logic [7:0]  r_txd, w_txd;
  logic [18:0] r_addr, w_addr;
  logic [7:0]  r_dout, w_dout;
  logic        r_we_n, w_we_n;
  logic [16:0] r_cnt, w_cnt;
  logic [7:0]  r_we_cnt, w_we_cnt;

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state;
    end
  end

  // Next-state and next-output decode; every output is registered one edge later
  always_comb begin
    w_state     = r_state;
    w_busy      = r_busy;
    w_done      = r_done;
    w_cs_n      = r_cs_n;
    w_spi_start = 1'b0;
    w_txd       = r_txd;
    w_addr      = r_addr;
    w_dout      = r_dout;
    w_we_n      = 1'b1;
    w_cnt       = r_cnt;
    w_we_cnt    = r_we_cnt;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          w_state = ST_CS_SETUP;
          w_busy  = 1'b1;
          w_done  = 1'b0;
          w_cnt   = 17'd0;
          w_addr  = SRAM_BASE;
          w_cs_n  = 1'b0;
        end else begin
          w_state = r_state;
        end
      end
      ST_CS_SETUP: begin
        w_state     = ST_CMD;
        w_spi_start = 1'b1;
        w_txd       = CMD_BYTE;
      end
      ST_CMD: begin
        if (i_spi_done) begin
          w_state     = ST_ADDR2;
          w_spi_start = 1'b1;
          w_txd       = FLASH_BASE[23:16];
        end else begin
          w_state = r_state;
        end
      end
      ST_ADDR2: begin
        if (i_spi_done) begin
          w_state     = ST_ADDR1;
          w_spi_start = 1'b1;
          w_txd       = FLASH_BASE[15:8];
        end else begin
          w_state = r_state;
        end
      end
      ST_ADDR1: begin
        if (i_spi_done) begin
          w_state     = ST_ADDR0;
          w_spi_start = 1'b1;
          w_txd       = FLASH_BASE[7:0];
        end else begin
          w_state = r_state;
        end
      end
      ST_ADDR0: begin
        if (i_spi_done) begin
          w_spi_start = 1'b1;
`ifdef FLASH_ROM_LOADER_FAST_READ_EN
          w_state     = ST_DUMMY;
          w_txd       = 8'h00;
`else
          w_state     = ST_RD_REQ;
          w_txd       = 8'hFF;
`endif
        end else begin
          w_state = r_state;
        end
      end
`ifdef FLASH_ROM_LOADER_FAST_READ_EN
      ST_DUMMY: begin
        if (i_spi_done) begin
          w_state     = ST_RD_REQ;
          w_spi_start = 1'b1;
          w_txd       = 8'hFF;
        end else begin
          w_state = r_state;
        end
      end
`endif
      ST_RD_REQ: begin
        w_state = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (i_spi_done) begin
          w_state = ST_WR_SETUP;
          w_dout  = i_spi_rxd;
        end else begin
          w_state = r_state;
        end
      end
      ST_WR_SETUP: begin
        w_state  = ST_WR_PULSE;
        w_we_n   = 1'b0;
        w_we_cnt = 8'd0;
      end
      ST_WR_PULSE: begin
        // Stray spi_done is not looked at here, so it cannot disturb the write
        if (r_we_cnt == WE_LAST) begin
          w_state = ST_WR_HOLD;
          w_we_n  = 1'b1;
        end else begin
          w_we_n   = 1'b0;
          w_we_cnt = r_we_cnt + 8'd1;
        end
      end
      ST_WR_HOLD: begin
        if (r_cnt == LAST_BYTE) begin
          w_state = ST_CS_RELEASE;
          w_cs_n  = 1'b1;
        end else begin
          w_state     = ST_RD_REQ;
          w_cnt       = r_cnt + 17'd1;
          w_addr      = r_addr + 19'd1;
          w_spi_start = 1'b1;
          w_txd       = 8'hFF;
        end
      end
      ST_CS_RELEASE: begin
        w_state = ST_DONE;
        w_busy  = 1'b0;
        w_done  = 1'b1;
      end
      default: begin
        w_state = ST_IDLE;
        w_busy  = 1'b0;
        w_done  = 1'b0;
        w_cs_n  = 1'b1;
      end
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_cs_n      <= 1'b1;
      r_spi_start <= 1'b0;
      r_txd       <= 8'h00;
      r_addr      <= SRAM_BASE;
      r_dout      <= 8'h00;
      r_we_n      <= 1'b1;
      r_cnt       <= 17'd0;
      r_we_cnt    <= 8'd0;
    end else begin
      r_busy      <= w_busy;
      r_done      <= w_done;
      r_cs_n      <= w_cs_n;
      r_spi_start <= w_spi_start;
      r_txd       <= w_txd;
      r_addr      <= w_addr;
      r_dout      <= w_dout;
      r_we_n      <= w_we_n;
      r_cnt       <= w_cnt;
      r_we_cnt    <= w_we_cnt;
    end
  end

  assign o_busy      = r_busy;
  assign o_done      = r_done;
  assign o_spi_cs_n  = r_cs_n;
  assign o_spi_start = r_spi_start;
  assign o_spi_txd   = r_txd;
  assign o_sram_addr = r_addr;
  assign o_sram_dout = r_dout;
  assign o_sram_we_n = r_we_n;

endmodule
